seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector. Successor to the fixed 3-bit Mealy "011" detector.
- Pattern and length are loaded at run time, up to MAX_LEN bits. Overlapping or non-overlapping detection is selectable.
- Input is qualified by a valid strobe. A saturating match counter is provided.
- Sits on a serial bitstream path, for example frame-sync or preamble search ahead of a deserialiser.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2).
- LEN_W, 4, width of pat_len; must hold MAX_LEN.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only when high.
- cfg_load  input  1  one-cycle strobe; latches pattern, pat_len and overlap_en.
- pattern  input  MAX_LEN  pattern bits; pattern[pat_len-1] is the first bit received, pattern[0] the last.
- pat_len  input  LEN_W  pattern length; legal range 1..MAX_LEN.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_count.
- match  output  1  registered one-cycle pulse.
- match_count  output  CNT_W  saturating count of matches.
- armed  output  1  high while a legal configuration is loaded (state RUN).
- cfg_err  output  1  one-cycle pulse when cfg_load carries an illegal pat_len.

Behaviour:
Reset (async, rst=1):
- State = IDLE.
- Internal registers cleared: history, fill and config (pattern, length, overlap_en).
- Outputs: match=0, match_count=0, armed=0, cfg_err=0.

State IDLE:
- din is ignored; match is never asserted.
- cfg_load with legal pat_len: latch config, clear history and fill, go to RUN.
- cfg_load with pat_len=0 or pat_len>MAX_LEN: pulse cfg_err for one cycle, stay in IDLE, keep previous config cleared.

State RUN:
- armed=1.
- On a clock edge with din_valid=1:
  - hist_n = {hist[MAX_LEN-2:0], din}.
  - fill_n = min(fill+1, MAX_LEN).
  - Hit when fill_n ≥ len and hist_n[len-1:0] == pattern[len-1:0].
- Hit: match=1 on the edge that samples the final pattern bit. This gives the same timing as the registered Mealy out of the predecessor.
- Hit with overlap_en=0: fill is set to 0, so no bit of the matched pattern is reused.
- Hit with overlap_en=1: fill = fill_n, so a suffix can start the next match.
- din_valid=0: history and fill hold; match=0.
- cfg_load in RUN:
  - Legal pat_len: reconfigure, clear history and fill, stay in RUN. No match in that cycle.
  - Illegal pat_len: cfg_err pulse, go to IDLE.
- cfg_load has priority over din_valid in the same cycle. The din bit in that cycle is dropped.

Match and counter:
- match is high for exactly one cycle per hit. Back-to-back hits on consecutive valid cycles give consecutive pulses; possible in overlap mode, e.g. pattern "11" on "111".
- match_count increments on each hit.
- match_count saturates at 2^CNT_W-1 and does not wrap.
- cnt_clr has priority: a simultaneous hit sets match still, but match_count=0 after the edge.

Reset mid-stream:
- Asynchronous reset immediately forces all outputs low or zero.
- Config must be reloaded after reset.

Test Plan:
1. Reset, then cfg_load pattern=8'b011, len=3, overlap=0. Stream 0,1,1,0,1,1 (valid every cycle) -> match pulses after bits 3 and 6; match_count=2.
2. pattern=4'b0101, len=4, overlap=1. Stream 0,1,0,1,0,1,0 -> match after bits 4 and 6; count=2. Repeat with overlap=0 -> match after bit 4 only; count=1.
3. pattern=3'b011, len=3, overlap=0. Stream 0,1,1 with din_valid low for 2 cycles between every bit -> single match after the third valid bit; no pulses on invalid cycles.
4. cfg_load pat_len=0 and, separately, pat_len=9 (MAX_LEN=8) -> cfg_err pulse, armed=0. A following matching stream gives no match.
5. CNT_W=2, pattern=1'b1, len=1, overlap=1. Feed 5 ones -> 5 match pulses; match_count sticks at 3. cnt_clr asserted concurrently with the 6th hit -> match=1, match_count=0.
6. rst asserted between two clock edges mid-pattern, after 0,1 of "011" -> outputs zero immediately, armed=0. After release, the bit 1 produces no match until reconfigured.

Source files
------------

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - run-time configurable serial bit-pattern detector
//
// Purpose:
//   Searches a valid-qualified serial bitstream for a pattern of 1..MAX_LEN
//   bits loaded at run time. Supports overlapping or non-overlapping
//   detection and keeps a saturating match counter.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   din         in   serial data bit
//   din_valid   in   din is sampled only when high
//   cfg_load    in   one-cycle strobe latching pattern / pat_len / overlap_en
//   pattern     in   [MAX_LEN] pattern[pat_len-1] is the first bit received
//   pat_len     in   [LEN_W] pattern length, legal range 1..MAX_LEN
//   overlap_en  in   1 = overlapping detection, 0 = non-overlapping
//   cnt_clr     in   synchronous clear of match_count (wins over a hit)
//   match       out  registered one-cycle pulse per hit
//   match_count out  [CNT_W] saturating hit count
//   armed       out  high while a legal configuration is loaded
//   cfg_err     out  one-cycle pulse when cfg_load carries an illegal pat_len

module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [MAX_LEN-1:0]   r_hist;
    logic [LEN_W-1:0]     r_fill;
    logic [MAX_LEN-1:0]   r_pattern;
    logic [LEN_W-1:0]     r_len;
    logic                 r_overlap;
    logic                 r_match;
    logic [CNT_W-1:0]     r_count;
    logic                 r_cfg_err;

    state_t               w_state_n;
    logic [MAX_LEN-1:0]   w_hist_shift;
    logic [LEN_W-1:0]     w_fill_inc;
    logic [MAX_LEN-1:0]   w_mask;
    logic                 w_cmp_hit;
    logic                 w_len_ok;
    logic [MAX_LEN-1:0]   w_hist_n;
    logic [LEN_W-1:0]     w_fill_n;
    logic [MAX_LEN-1:0]   w_pattern_n;
    logic [LEN_W-1:0]     w_len_n;
    logic                 w_overlap_n;
    logic                 w_hit;
    logic                 w_cfg_err_n;
    logic [CNT_W-1:0]     w_count_n;

    // Candidate history/fill as if the current din were accepted.
    assign w_hist_shift = {r_hist[MAX_LEN-2:0], din};
    assign w_fill_inc   = (r_fill >= LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
    assign w_len_ok     = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

    // Only the low r_len bits of history take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_cmp_hit = (w_fill_inc >= r_len) &&
                       (((w_hist_shift ^ r_pattern) & w_mask) == '0);

    always_comb begin
        w_state_n   = r_state;
        w_hist_n    = r_hist;
        w_fill_n    = r_fill;
        w_pattern_n = r_pattern;
        w_len_n     = r_len;
        w_overlap_n = r_overlap;
        w_hit       = 1'b0;
        w_cfg_err_n = 1'b0;

        if (cfg_load) begin
            // A load always restarts the search; any din this cycle is dropped.
            w_hist_n = '0;
            w_fill_n = '0;
            if (w_len_ok) begin
                w_pattern_n = pattern;
                w_len_n     = pat_len;
                w_overlap_n = overlap_en;
                w_state_n   = S_RUN;
            end else begin
                w_pattern_n = '0;
                w_len_n     = '0;
                w_overlap_n = 1'b0;
                w_cfg_err_n = 1'b1;
                w_state_n   = S_IDLE;
            end
        end else if (r_state == S_RUN && din_valid) begin
            w_hist_n = w_hist_shift;
            if (w_cmp_hit) begin
                w_hit    = 1'b1;
                // Non-overlap mode discards every bit of the matched pattern.
                w_fill_n = r_overlap ? w_fill_inc : '0;
            end else begin
                w_fill_n = w_fill_inc;
            end
        end
    end

    always_comb begin
        w_count_n = r_count;
        if (cnt_clr) begin
            w_count_n = '0;
        end else if (w_hit && (r_count != {CNT_W{1'b1}})) begin
            w_count_n = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_match   <= 1'b0;
            r_count   <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_hist    <= w_hist_n;
            r_fill    <= w_fill_n;
            r_pattern <= w_pattern_n;
            r_len     <= w_len_n;
            r_overlap <= w_overlap_n;
            r_match   <= w_hit;
            r_count   <= w_count_n;
            r_cfg_err <= w_cfg_err_n;
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign armed       = (r_state == S_RUN);
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param

module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               din = 1'b0;
    logic               din_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] pattern = '0;
    logic [LEN_W-1:0]   pat_len = '0;
    logic               overlap_en = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               armed;
    logic               cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .cfg_load   (cfg_load),
        .pattern    (pattern),
        .pat_len    (pat_len),
        .overlap_en (overlap_en),
        .cnt_clr    (cnt_clr),
        .match      (match),
        .match_count(match_count),
        .armed      (armed),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic b, input logic v, input logic clr);
        din       = b;
        din_valid = v;
        cnt_clr   = clr;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic ovl);
        pattern    = p;
        pat_len    = l;
        overlap_en = ovl;
        cfg_load   = 1'b1;
        @(posedge clk);
        #1;
        cfg_load   = 1'b0;
    endtask

    // bits/exp are strings of '0'/'1', first character = first bit sent.
    task automatic run_bits(input string tag, input string bits, input string exp);
        for (int i = 0; i < bits.len(); i++) begin
            step(bits[i] == "1", 1'b1, 1'b0);
            check($sformatf("%s_m%0d", tag, i), 32'(match), 32'(exp[i] == "1"));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_match", 32'(match), 0);
        check("rst_count", 32'(match_count), 0);
        check("rst_armed", 32'(armed), 0);
        check("rst_cfgerr", 32'(cfg_err), 0);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        check("idle_ignore", 32'(match), 0);

        // 1: "011" non-overlap
        load(8'b011, 4'd3, 1'b0);
        check("t1_armed", 32'(armed), 1);
        check("t1_match_load", 32'(match), 0);
        run_bits("t1", "011011", "001001");
        check("t1_count", 32'(match_count), 2);

        // 2: "0101" overlap then non-overlap
        step(1'b0, 1'b0, 1'b1);
        check("t2_clr", 32'(match_count), 0);
        load(8'b0101, 4'd4, 1'b1);
        run_bits("t2o", "0101010", "0001010");
        check("t2o_count", 32'(match_count), 2);
        step(1'b0, 1'b0, 1'b1);
        load(8'b0101, 4'd4, 1'b0);
        run_bits("t2n", "0101010", "0001000");
        check("t2n_count", 32'(match_count), 1);

        // 3: gaps of invalid cycles between bits (din toggled to show it is ignored)
        step(1'b0, 1'b0, 1'b1);
        load(8'b011, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step((i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0);
            check($sformatf("t3_v%0d", i), 32'(match), (i == 2) ? 1 : 0);
            for (int g = 0; g < 2; g++) begin
                step((i == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
                check($sformatf("t3_gap%0d_%0d", i, g), 32'(match), 0);
            end
        end
        check("t3_count", 32'(match_count), 1);

        // 4: illegal lengths
        step(1'b0, 1'b0, 1'b1);
        load(8'b011, 4'd0, 1'b0);
        check("t4_err0", 32'(cfg_err), 1);
        check("t4_armed0", 32'(armed), 0);
        step(1'b0, 1'b0, 1'b0);
        check("t4_err0_pulse", 32'(cfg_err), 0);
        run_bits("t4a", "011", "000");
        load(8'b011, 4'd9, 1'b0);
        check("t4_err9", 32'(cfg_err), 1);
        check("t4_armed9", 32'(armed), 0);
        run_bits("t4b", "011", "000");
        check("t4_count", 32'(match_count), 0);

        // 5: len 1, overlap, saturation at 3 and cnt_clr vs hit
        load(8'b1, 4'd1, 1'b1);
        check("t5_cfgerr", 32'(cfg_err), 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check($sformatf("t5_m%0d", i), 32'(match), 1);
            check($sformatf("t5_c%0d", i), 32'(match_count), (i < 3) ? i + 1 : 3);
        end
        step(1'b1, 1'b1, 1'b1);
        check("t5_clr_match", 32'(match), 1);
        check("t5_clr_count", 32'(match_count), 0);

        // cfg_load beats din_valid: the "1" completing "011" is dropped
        load(8'b011, 4'd3, 1'b0);
        run_bits("t7a", "01", "00");
        din = 1'b1;
        din_valid = 1'b1;
        load(8'b011, 4'd3, 1'b0);
        din_valid = 1'b0;
        check("t7_prio", 32'(match), 0);
        run_bits("t7b", "1011", "0001");

        // 6: async reset mid-stream
        check("t6_pre_count", 32'(match_count), 1);
        load(8'b011, 4'd3, 1'b0);
        run_bits("t6", "01", "00");
        rst = 1'b1;
        #2;
        check("t6_async_count", 32'(match_count), 0);
        check("t6_async_armed", 32'(armed), 0);
        check("t6_async_match", 32'(match), 0);
        #2;
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        check("t6_post_match", 32'(match), 0);
        check("t6_post_armed", 32'(armed), 0);
        run_bits("t6b", "011", "000");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
